// File: rtl/mem_store_monitor_if.sv
// Core memory-bus snoop and FIFO drain port of mem_store_monitor.
// master = core/consumer side, slave = monitor side.
interface mem_store_monitor_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          MemWrite;
  logic [31:0]   Adr;
  logic [31:0]   WriteData;
  logic [31:0]   PC;
  logic          rd_en;
  logic          rd_valid;
  logic [31:0]   rd_adr;
  logic [31:0]   rd_data;
  logic [31:0]   rd_pc;
  logic [CW-1:0] count;

  modport slave (
    input  MemWrite, Adr, WriteData, PC, rd_en,
    output rd_valid, rd_adr, rd_data, rd_pc, count
  );

  modport master (
    output MemWrite, Adr, WriteData, PC, rd_en,
    input  rd_valid, rd_adr, rd_data, rd_pc, count
  );
endinterface

// File: rtl/mem_store_monitor.sv
// Store monitor: captures core stores into a show-ahead FIFO and detects end-of-test.
// Optional watchdog enabled by defining MON_WATCHDOG_EN.
module mem_store_monitor #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] DONE_ADDR = 32'h0000_0064,
  parameter logic [31:0] DONE_DATA = 32'h0000_0007,
  parameter int          TIMEOUT   = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  mem_store_monitor_if.slave  bus,
  output logic                overflow,
  output logic [15:0]         store_cnt,
  output logic                done,
  output logic                pass,
  output logic                timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  state_t        r_state;
  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_store_cnt;

  logic   w_cap, w_end, w_pop, w_push, w_full;
  entry_t w_head;

  assign w_cap  = (r_state == RUN) && bus.MemWrite;
  assign w_end  = w_cap && (bus.Adr == DONE_ADDR);
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = bus.rd_en && (r_count != '0);
  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign w_push = w_cap && (!w_full || w_pop);

`ifdef MON_WATCHDOG_EN
  logic [31:0] r_wdog;
  logic        r_to;
  logic [31:0] w_wdog_nxt;
  assign w_wdog_nxt = r_wdog + 32'd1;
  assign timeout    = r_to;
`else
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_store_cnt <= '0;
`ifdef MON_WATCHDOG_EN
      r_wdog      <= '0;
      r_to        <= 1'b0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_cap && !w_push) r_overflow <= 1'b1;
      if (w_cap && (r_store_cnt != 16'hFFFF)) r_store_cnt <= r_store_cnt + 16'd1;

      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
`ifdef MON_WATCHDOG_EN
          r_wdog  <= '0;
`endif
        end
        RUN: begin
          // The end-of-test store takes priority over a coincident watchdog expiry.
          if (w_end) begin
            r_state <= (bus.WriteData == DONE_DATA) ? PASS : FAIL;
          end
`ifdef MON_WATCHDOG_EN
          else begin
            r_wdog <= w_wdog_nxt;
            if (w_wdog_nxt == 32'(TIMEOUT)) begin
              r_state <= FAIL;
              r_to    <= 1'b1;
            end
          end
`endif
        end
        default: r_state <= r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{adr: bus.Adr, data: bus.WriteData, pc: bus.PC};
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign bus.rd_valid = (r_count != '0);
  assign bus.rd_adr   = bus.rd_valid ? w_head.adr  : '0;
  assign bus.rd_data  = bus.rd_valid ? w_head.data : '0;
  assign bus.rd_pc    = bus.rd_valid ? w_head.pc   : '0;
  assign bus.count    = r_count;

  assign overflow  = r_overflow;
  assign store_cnt = r_store_cnt;
  assign done      = (r_state == PASS) || (r_state == FAIL);
  assign pass      = (r_state == PASS);
endmodule

// File: doc/mem_store_monitor.md
Name: mem_store_monitor

Overview:
- Bus-side monitor directly downstream of the multicycle ARM core's memory interface (PC, Adr, WriteData, MemWrite).
- Captures every store the core issues into a small show-ahead FIFO, which the checker drains.
- Detects the program's end-of-test store and reports pass or fail.
- Synthesizable replacement for ad-hoc bench snooping; usable in simulation and on FPGA with a debug UART draining the FIFO.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- DONE_ADDR, 32'h00000064: address of the end-of-test store.
- DONE_DATA, 32'h00000007: value the end-of-test store must carry for pass.
- TIMEOUT, 1000: cycles in RUN without an end-of-test store before fail; only used with MON_WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms the monitor (IDLE to RUN).
- MemWrite  in  1  core store strobe, high for one cycle per store.
- Adr  in  32  store address.
- WriteData  in  32  store data.
- PC  in  32  core PC at the store cycle.
- rd_en  in  1  pop request from the consumer.
- rd_valid  out  1  FIFO non-empty; head entry is valid.
- rd_adr  out  32  head entry address.
- rd_data  out  32  head entry data.
- rd_pc  out  32  head entry PC.
- count  out  $clog2(DEPTH+1)  current number of FIFO entries.
- overflow  out  1  sticky; a store was dropped because the FIFO was full.
- store_cnt  out  16  total stores observed in RUN; saturates at 16'hFFFF.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS.
- timeout  out  1  high if FAIL was caused by the watchdog.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately, including mid-operation):
  - state = IDLE; FIFO emptied; count = 0.
  - rd_valid = 0; rd_adr, rd_data, rd_pc = 0.
  - overflow = 0; store_cnt = 0; done = 0; pass = 0; timeout = 0; watchdog = 0.
- FSM states IDLE, RUN, PASS, FAIL:
  - IDLE: MemWrite ignored. start=1 moves to RUN on the next edge.
  - RUN: a capture occurs on every edge where MemWrite=1.
    - If Adr==DONE_ADDR and WriteData==DONE_DATA: go to PASS.
    - If Adr==DONE_ADDR and WriteData!=DONE_DATA: go to FAIL.
    - The end-of-test store itself is still captured into the FIFO.
  - PASS and FAIL are terminal until reset. start is ignored. No further captures and no store_cnt changes.
  - start while in RUN is ignored.
- Capture in RUN:
  - Push {Adr, WriteData, PC} sampled on the same edge as MemWrite.
  - store_cnt increments on every capture, whether or not the push is dropped.
- FIFO:
  - Show-ahead: the head entry is presented on rd_* combinationally from storage whenever rd_valid=1.
  - A pop happens on an edge where rd_en=1 and rd_valid=1. rd_en while empty is a no-op.
  - Latency: a pushed entry appears on rd_* and rd_valid the cycle after its capture edge.
  - Push and pop on the same edge: both take effect and count is unchanged. This includes the full case (pop frees a slot, push is accepted).
  - Push when full with no pop: entry dropped, overflow set (sticky), count stays at DEPTH, existing entries untouched.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately to distinguish full from empty.
  - Draining is allowed in any state, including PASS and FAIL.
- Outputs are registered except rd_*, rd_valid and count, which are derived from FIFO registers.
- done, pass and timeout are decoded from the state register plus a timeout flag register.

Optional Feature:
- MON_WATCHDOG_EN defined:
  - A 32-bit watchdog is cleared on entry to RUN and increments every RUN cycle.
  - When it reaches TIMEOUT with no end-of-test store: state goes to FAIL and timeout=1.
  - If the end-of-test store lands on the same edge the watchdog reaches TIMEOUT, the store wins (PASS or FAIL by data) and timeout=0.
- MON_WATCHDOG_EN undefined: no watchdog logic; RUN persists indefinitely; timeout is tied to 0.

Test Plan:
- Reset then start, then 3 stores ({0x50,0x1}, {0x54,0x2}, {0x58,0x3}) with no pops -> count=3, store_cnt=3, rd_adr=0x50, rd_data=0x1; three pops return the entries in order, then rd_valid=0.
- With DEPTH=8: 10 stores, no pops -> count=8, overflow=1, store_cnt=10; the drained entries are the first 8 stores.
- FIFO full, then MemWrite and rd_en on the same edge -> count stays 8, overflow stays 0, new entry is last in drain order.
- Store {0x64, 0x7} in RUN -> next cycle done=1, pass=1, timeout=0. A later store {0x70,0x9} is not captured and store_cnt is unchanged.
- Store {0x64, 0x5} -> done=1, pass=0. With MON_WATCHDOG_EN and TIMEOUT=20: no stores for 20 RUN cycles -> done=1, pass=0, timeout=1.
- reset_n low mid-RUN with count=4 -> outputs zero immediately and state is IDLE. Stores before the next start are ignored (count stays 0).
